// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR symbol generator.
// Tap masks are for XNOR Fibonacci LFSRs: bit i set means stage i+1 is tapped.
package lfsr_pkg;

   localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;        // taps 4,3
   localparam logic [6:0]  LFSR_TAPS_7  = 7'h60;          // taps 7,6
   localparam logic [14:0] LFSR_TAPS_15 = 15'h6000;       // taps 15,14
   localparam logic [21:0] LFSR_TAPS_22 = 22'h300000;     // taps 22,21
   localparam logic [30:0] LFSR_TAPS_31 = 31'h48000000;   // taps 31,28

   // True when the low w bits of v are all ones (the XNOR lock-up state).
   function automatic logic is_all_ones(input logic [63:0] v, input int unsigned w);
      logic r;
      r = 1'b1;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < w && !v[i[5:0]]) r = 1'b0;
      end
      return r;
   endfunction

   // Legal configuration: width in range, seed not stuck, symbol/step counts fit.
   function automatic logic cfg_ok(input int unsigned w, input logic [63:0] seed,
                                   input int unsigned sym_bits, input int unsigned steps);
      return (w >= 3) && (w <= 64) && !is_all_ones(seed, w) &&
             (sym_bits >= 1) && (sym_bits <= w) && (steps >= 1) && (steps <= w);
   endfunction

endpackage

// File: rtl/lfsr_sym_gen_if.sv
// Symbol handshake bundle between the LFSR generator and its consumer.
interface lfsr_sym_gen_if #(
   parameter int unsigned SYM_BITS = 4
) ();

   logic                sym_valid;
   logic                sym_ready;
   logic [SYM_BITS-1:0] sym_out;

   modport master (output sym_valid, output sym_out, input sym_ready);
   modport slave  (input sym_valid, input sym_out, output sym_ready);

endinterface

// File: rtl/lfsr_nstep.sv
// Combinational N-step advance of an XNOR Fibonacci LFSR.
module lfsr_nstep
   import lfsr_pkg::*;
#(
   parameter int unsigned     W        = 22,
   parameter logic [W-1:0]    TAP_MASK = LFSR_TAPS_22,
   parameter int unsigned     N        = 1
) (
   input  logic [W-1:0] state,
   output logic [W-1:0] advanced
);

   // Chain N single steps: shift left, feed XNOR of tapped stages into bit 0.
   always_comb begin
      logic [W-1:0] s;
      s = state;
      for (int unsigned i = 0; i < N; i++) begin
         s = {s[W-2:0], ~^(s & TAP_MASK)};
      end
      advanced = s;
   end

endmodule

// File: rtl/lfsr_sym_gen.sv
// LFSR symbol generator: N-step XNOR LFSR with valid/ready symbol output,
// runtime reseed and all-ones lock-up protection.
// Optional macro LFSR_SYM_GEN_PERIOD_MON_EN adds period_wrap / step_cnt outputs.
module lfsr_sym_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned              LFSR_WIDTH    = 22,
   parameter logic [LFSR_WIDTH-1:0]    TAP_MASK      = LFSR_TAPS_22,
   parameter logic [LFSR_WIDTH-1:0]    LFSR_SEED     = 22'h1D6F57,
   parameter int unsigned              SYM_BITS      = 4,
   parameter int unsigned              STEPS_PER_SYM = SYM_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed_in,
   lfsr_sym_gen_if.master        sym_if,
   output logic [LFSR_WIDTH-1:0] seq_out,
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
   output logic                  period_wrap,
   output logic [LFSR_WIDTH-1:0] step_cnt,
`endif
   output logic                  lockup_err
);

   if (!cfg_ok(LFSR_WIDTH, 64'(LFSR_SEED), SYM_BITS, STEPS_PER_SYM)) begin : g_cfg_err
      $error("lfsr_sym_gen: illegal parameter configuration");
   end

   logic [LFSR_WIDTH-1:0] state_q;
   logic [LFSR_WIDTH-1:0] state_next;
   logic [LFSR_WIDTH-1:0] seed_eff;
   logic [SYM_BITS-1:0]   sym_q;
   logic                  valid_q;
   logic                  lockup_q;
   logic                  seed_bad;
   logic                  advance;

   lfsr_nstep #(
      .W        (LFSR_WIDTH),
      .TAP_MASK (TAP_MASK),
      .N        (STEPS_PER_SYM)
   ) u_nstep (
      .state    (state_q),
      .advanced (state_next)
   );

   assign seed_bad = is_all_ones(64'(seed_in), LFSR_WIDTH);
   assign seed_eff = seed_bad ? LFSR_SEED : seed_in;
   assign advance  = clk_en & (~valid_q | sym_if.sym_ready);

   // State, symbol and handshake registers; reset > seed_load > advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= LFSR_SEED;
         sym_q    <= '0;
         valid_q  <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         lockup_q <= 1'b0;
         if (seed_load) begin
            state_q  <= seed_eff;
            valid_q  <= 1'b0;
            lockup_q <= seed_bad;
         end else if (advance) begin
            state_q <= state_next;
            sym_q   <= state_next[SYM_BITS-1:0];
            valid_q <= 1'b1;
         end else if (valid_q && sym_if.sym_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign sym_if.sym_valid = valid_q;
   assign sym_if.sym_out   = sym_q;
   assign seq_out          = state_q;
   assign lockup_err       = lockup_q;

`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
   localparam logic [LFSR_WIDTH-1:0] ONE = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

   logic [LFSR_WIDTH-1:0] last_seed_q;
   logic [LFSR_WIDTH-1:0] cnt_q;
   logic                  wrap_q;

   // Period monitor: counts advances since the last load and flags the return to it.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_seed_q <= LFSR_SEED;
         cnt_q       <= '0;
         wrap_q      <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (seed_load) begin
            last_seed_q <= seed_eff;
            cnt_q       <= '0;
         end else if (advance) begin
            if (state_next == last_seed_q) begin
               wrap_q <= 1'b1;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + ONE;
            end
         end
      end
   end

   assign period_wrap = wrap_q;
   assign step_cnt    = cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_sym_gen.sv
// Bench for lfsr_sym_gen: a W=4 instance with hand-computed sequences and the
// default W=22 instance under random handshake traffic. Accepted symbols are
// checked by a scoreboard monitor; control behaviour by directed checks.
module tb_lfsr_sym_gen;

   typedef struct {
      logic [21:0] state;
      logic [3:0]  sym;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   exp_t q4[$];
   exp_t q22[$];
   exp_t e4, e22;

   // Hand-computed W=4 sequence from 0000, taps 4,3, XNOR feedback.
   logic [3:0] seq4_tab [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

   // ---------------- W=4 instance ----------------
   logic       rst4 = 1'b1, en4 = 1'b0, ld4 = 1'b0, lock4;
   logic [3:0] sin4 = '0, seq4;
   lfsr_sym_gen_if #(.SYM_BITS(1)) bus4 ();
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
   logic       wrap4;
   logic [3:0] cnt4;
   int unsigned wrap_cnt4 = 0;
`endif

   lfsr_sym_gen #(
      .LFSR_WIDTH    (4),
      .TAP_MASK      (4'b1100),
      .LFSR_SEED     (4'b0000),
      .SYM_BITS      (1),
      .STEPS_PER_SYM (1)
   ) dut4 (
      .clk         (clk),
      .reset       (rst4),
      .clk_en      (en4),
      .seed_load   (ld4),
      .seed_in     (sin4),
      .sym_if      (bus4),
      .seq_out     (seq4),
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
      .period_wrap (wrap4),
      .step_cnt    (cnt4),
`endif
      .lockup_err  (lock4)
   );

   // ---------------- default W=22 instance ----------------
   logic        rst22 = 1'b1, en22 = 1'b0, ld22 = 1'b0, lock22;
   logic [21:0] sin22 = '0, seq22;
   lfsr_sym_gen_if #(.SYM_BITS(4)) bus22 ();
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
   logic        wrap22;
   logic [21:0] cnt22;
`endif

   lfsr_sym_gen dut22 (
      .clk         (clk),
      .reset       (rst22),
      .clk_en      (en22),
      .seed_load   (ld22),
      .seed_in     (sin22),
      .sym_if      (bus22),
      .seq_out     (seq22),
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
      .period_wrap (wrap22),
      .step_cnt    (cnt22),
`endif
      .lockup_err  (lock22)
   );

   // Reference step for the default config: taps 22,21, four shifts per symbol.
   function automatic logic [21:0] ref_sym22(input logic [21:0] s);
      logic [21:0] r;
      r = s;
      for (int k = 0; k < 4; k++) r = {r[20:0], ~(r[21] ^ r[20])};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait until the scoreboard queue of one instance has been consumed.
   task automatic drain(input bit wide, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if ((wide ? q22.size() : q4.size()) == 0) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d symbols still pending", wide ? q22.size() : q4.size());
   endtask

   function automatic exp_t mk4(input logic [3:0] s);
      exp_t e;
      e.state = {18'b0, s};
      e.sym   = {3'b0, s[0]};
      return e;
   endfunction

   // Scoreboard monitor: every accepted transfer must match the next expected symbol.
   always @(negedge clk) begin
      if (bus4.sym_valid && bus4.sym_ready) begin
         n_cmp++;
         if (q4.size() == 0) begin
            n_err++;
            $display("FAIL sym4_extra: got state %0h with nothing expected", seq4);
         end else begin
            e4 = q4.pop_front();
            if (seq4 !== e4.state[3:0] || bus4.sym_out !== e4.sym[0]) begin
               n_err++;
               $display("FAIL sym4: got state %0h sym %0h expected state %0h sym %0h",
                        seq4, bus4.sym_out, e4.state[3:0], e4.sym[0]);
            end
         end
      end
      if (bus22.sym_valid && bus22.sym_ready) begin
         n_cmp++;
         if (q22.size() == 0) begin
            n_err++;
            $display("FAIL sym22_extra: got state %0h with nothing expected", seq22);
         end else begin
            e22 = q22.pop_front();
            if (seq22 !== e22.state || bus22.sym_out !== e22.sym) begin
               n_err++;
               $display("FAIL sym22: got state %0h sym %0h expected state %0h sym %0h",
                        seq22, bus22.sym_out, e22.state, e22.sym);
            end
         end
      end
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
      if (wrap4) wrap_cnt4++;
`endif
   end

   initial begin
      logic [21:0] m;
      bus4.sym_ready  = 1'b0;
      bus22.sym_ready = 1'b0;
      step();
      step();

      // Reset state of both instances
      check("rst4_seq",    32'(seq4), 32'h0);
      check("rst4_valid",  32'(bus4.sym_valid), 32'h0);
      check("rst4_sym",    32'(bus4.sym_out), 32'h0);
      check("rst4_lock",   32'(lock4), 32'h0);
      check("rst22_seq",   32'(seq22), 32'h1D6F57);
      check("rst22_valid", 32'(bus22.sym_valid), 32'h0);

      // Full period at full rate from reset
      foreach (seq4_tab[i]) q4.push_back(mk4(seq4_tab[i]));
      rst4 = 1'b0;
      en4  = 1'b1;
      bus4.sym_ready = 1'b1;
      step();
      check("lat4_seq",   32'(seq4), 32'h1);
      check("lat4_valid", 32'(bus4.sym_valid), 32'h1);
      drain(1'b0, 40);
      en4 = 1'b0;
      step();
      check("period4_seq",   32'(seq4), 32'h0);
      check("period4_valid", 32'(bus4.sym_valid), 32'h0);
`ifdef LFSR_SYM_GEN_PERIOD_MON_EN
      check("period4_wraps", 32'(wrap_cnt4), 32'h1);
      check("period4_cnt",   32'(cnt4), 32'h0);
`endif

      // Backpressure: symbol held while ready is low
      q4.push_back(mk4(4'h1));
      q4.push_back(mk4(4'h3));
      en4 = 1'b1;
      bus4.sym_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall4_seq",   32'(seq4), 32'h1);
         check("stall4_sym",   32'(bus4.sym_out), 32'h1);
         check("stall4_valid", 32'(bus4.sym_valid), 32'h1);
      end
      bus4.sym_ready = 1'b1;
      drain(1'b0, 20);
      en4 = 1'b0;
      step();
      check("post_stall4_seq",   32'(seq4), 32'h3);
      check("post_stall4_valid", 32'(bus4.sym_valid), 32'h0);

      // Reseed: all-ones rejected, then a legal seed flushes a pending symbol
      en4 = 1'b1;
      bus4.sym_ready = 1'b0;
      step();
      check("pend4_seq",   32'(seq4), 32'h7);
      check("pend4_valid", 32'(bus4.sym_valid), 32'h1);
      ld4  = 1'b1;
      sin4 = 4'hF;
      step();
      check("lock4_seq",   32'(seq4), 32'h0);
      check("lock4_pulse", 32'(lock4), 32'h1);
      check("lock4_valid", 32'(bus4.sym_valid), 32'h0);
      ld4 = 1'b0;
      en4 = 1'b0;
      step();
      check("lock4_end",     32'(lock4), 32'h0);
      check("lock4_hold",    32'(seq4), 32'h0);
      ld4  = 1'b1;
      sin4 = 4'h6;
      en4  = 1'b1;
      step();
      check("seed4_seq",   32'(seq4), 32'h6);
      check("seed4_valid", 32'(bus4.sym_valid), 32'h0);
      check("seed4_lock",  32'(lock4), 32'h0);
      ld4 = 1'b0;
      q4.push_back(mk4(4'hC));
      q4.push_back(mk4(4'h9));
      bus4.sym_ready = 1'b1;
      drain(1'b0, 20);
      en4 = 1'b0;
      bus4.sym_ready = 1'b0;
      step();

      // Default config: random clk_en / ready over 10k symbols
      m = 22'h1D6F57;
      for (int i = 0; i < 10000; i++) begin
         exp_t e;
         m = ref_sym22(m);
         e.state = m;
         e.sym   = m[3:0];
         q22.push_back(e);
      end
      rst22 = 1'b0;
      en22  = 1'b1;
      step();
      check("first22_seq",   32'(seq22), 32'h16F576);
      check("first22_sym",   32'(bus22.sym_out), 32'h6);
      check("first22_valid", 32'(bus22.sym_valid), 32'h1);
      begin
         int c;
         for (c = 0; c < 60000 && q22.size() != 0; c++) begin
            en22 = ($urandom_range(0, 3) != 0);
            bus22.sym_ready = ($urandom_range(0, 3) != 0);
            step();
         end
         if (q22.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rand22_timeout: %0d symbols still pending", q22.size());
         end
      end

      // Reset mid-stream with ready low
      bus22.sym_ready = 1'b0;
      en22 = 1'b1;
      step();
      step();
      check("mid22_valid", 32'(bus22.sym_valid), 32'h1);
      rst22 = 1'b1;
      step();
      check("mid22_rst_valid", 32'(bus22.sym_valid), 32'h0);
      check("mid22_rst_seq",   32'(seq22), 32'h1D6F57);
      check("mid22_rst_sym",   32'(bus22.sym_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
